// File: rtl/sensor_debouncer_pkg.sv
// Shared constants for the sensor conditioning block: sensor bit positions
// in the published vector, default timing parameters and a width helper.
package sensor_debouncer_pkg;

    // Bit positions of each sensor inside the published 4-bit vector.
    localparam int SENS_HEAD    = 3;
    localparam int SENS_LEFT    = 2;
    localparam int SENS_BARRIER = 1;
    localparam int SENS_UNDER   = 0;
    localparam int SENS_COUNT   = 4;

    // Default timing parameters (clocks).
    localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
    localparam int DEFAULT_FRAME_CYCLES    = 4;

    typedef logic [SENS_COUNT-1:0] sens_vec_t;

    // Width of a counter that must be able to hold the value max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sensor_debouncer_debounce_channel.sv
// One sensor channel: 2-FF synchroniser followed by a run-length debouncer.
// The stable bit only flips after DEBOUNCE_CYCLES consecutive clocks of the
// synchronised level disagreeing with it; any agreement restarts the count.
module debounce_channel
    import sensor_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable,
    output logic o_busy
);

    localparam int               CW         = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic [CW-1:0] r_count;

    // Two-flop synchroniser for the asynchronous sensor line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Count consecutive disagreeing clocks; accept the new level on the last one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stable <= 1'b0;
            r_count  <= '0;
        end else if (r_sync == r_stable) begin
            r_count  <= '0;
        end else if (r_count == COUNT_LAST) begin
            r_stable <= r_sync;
            r_count  <= '0;
        end else begin
            r_count  <= r_count + CW'(1);
        end
    end

    assign o_stable = r_stable;
    assign o_busy   = (r_count != '0);

endmodule

// File: rtl/sensor_debouncer.sv
// Conditions the four raw field sensors for the robot controller. Each line is
// synchronised and debounced per channel; the resulting stable vector is
// published as a whole once per frame so the consumer never sees a partially
// updated set of sensor levels.
module sensor_debouncer
    import sensor_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int FRAME_CYCLES    = DEFAULT_FRAME_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_head,
    input  logic raw_left,
    input  logic raw_barrier,
    input  logic raw_under,
    output logic head,
    output logic left,
    output logic barrier,
    output logic under,
    output logic sensors_valid,
    output logic changed,
    output logic settling
);

    localparam int            FW         = cnt_width(FRAME_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

    sens_vec_t     w_raw;
    sens_vec_t     w_stable;
    sens_vec_t     w_busy;
    logic          w_publish;

    logic [FW-1:0] r_frame;
    sens_vec_t     r_out;
    logic          r_valid;
    logic          r_changed;

    assign w_raw[SENS_HEAD]    = raw_head;
    assign w_raw[SENS_LEFT]    = raw_left;
    assign w_raw[SENS_BARRIER] = raw_barrier;
    assign w_raw[SENS_UNDER]   = raw_under;

    genvar gi;
    generate
        for (gi = 0; gi < SENS_COUNT; gi++) begin : g_channel
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_channel (
                .clock    (clock),
                .reset    (reset),
                .i_raw    (w_raw[gi]),
                .o_stable (w_stable[gi]),
                .o_busy   (w_busy[gi])
            );
        end
    endgenerate

    assign w_publish = (r_frame == FRAME_LAST);

    // Free-running frame counter; the publish happens on its last count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame <= '0;
        end else if (w_publish) begin
            r_frame <= '0;
        end else begin
            r_frame <= r_frame + FW'(1);
        end
    end

    // Snapshot all stable bits together and raise the one-clock strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end else if (w_publish) begin
            r_out     <= w_stable;
            r_valid   <= 1'b1;
            r_changed <= (w_stable != r_out);
        end else begin
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
        end
    end

    assign head          = r_out[SENS_HEAD];
    assign left          = r_out[SENS_LEFT];
    assign barrier       = r_out[SENS_BARRIER];
    assign under         = r_out[SENS_UNDER];
    assign sensors_valid = r_valid;
    assign changed       = r_changed;
    assign settling      = |w_busy;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Bench for sensor_debouncer: two instances (8/4 and 1/1 timing) share the raw
// inputs and reset. A window-based reference model predicts every cycle; table
// vectors and hand sequences cover glitches, bounce, coherence and reset.
module tb_sensor_debouncer;
    import sensor_debouncer_pkg::*;

    localparam int DA   = 8;
    localparam int FA   = 4;
    localparam int DB   = 1;
    localparam int FB   = 1;
    localparam int MAXE = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic raw_head = 1'b0, raw_left = 1'b0, raw_barrier = 1'b0, raw_under = 1'b0;

    logic a_head, a_left, a_barrier, a_under, a_valid, a_chg, a_settle;
    logic b_head, b_left, b_barrier, b_under, b_valid, b_chg, b_settle;
    logic [3:0] a_vec, b_vec;

    assign a_vec = {a_head, a_left, a_barrier, a_under};
    assign b_vec = {b_head, b_left, b_barrier, b_under};

    always #5 clk = ~clk;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DA), .FRAME_CYCLES(FA)) dut_a (
        .clock(clk), .reset(rst_n),
        .raw_head(raw_head), .raw_left(raw_left), .raw_barrier(raw_barrier), .raw_under(raw_under),
        .head(a_head), .left(a_left), .barrier(a_barrier), .under(a_under),
        .sensors_valid(a_valid), .changed(a_chg), .settling(a_settle)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DB), .FRAME_CYCLES(FB)) dut_b (
        .clock(clk), .reset(rst_n),
        .raw_head(raw_head), .raw_left(raw_left), .raw_barrier(raw_barrier), .raw_under(raw_under),
        .head(b_head), .left(b_left), .barrier(b_barrier), .under(b_under),
        .sensors_valid(b_valid), .changed(b_chg), .settling(b_settle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // raw_at[k] is the raw vector sampled at edge k after reset release.
    // The synchroniser output seen by edge j is the raw vector from edge j-2.
    // A stable bit flips at edge n when every sync value in the window of
    // the last D edges (all after the previous flip) disagrees with it.
    bit [3:0] raw_at [0:MAXE];
    int       n_edge;
    int       md [2] = '{DA, DB};
    int       mf [2] = '{FA, FB};
    bit [3:0] ms [2];
    int       lastf [2][4];
    bit [3:0] mout [2];
    bit       mvalid [2];
    bit       mchg [2];
    bit       msettle [2];

    function automatic bit [3:0] sync_b(input int j);
        return (j >= 3) ? raw_at[j-2] : 4'b0000;
    endfunction

    task automatic model_reset();
        n_edge = 0;
        for (int m = 0; m < 2; m++) begin
            ms[m] = 4'b0; mout[m] = 4'b0; mvalid[m] = 1'b0; mchg[m] = 1'b0; msettle[m] = 1'b0;
            for (int ch = 0; ch < 4; ch++) lastf[m][ch] = 0;
        end
    endtask

    task automatic model_edge(input bit [3:0] r);
        bit [3:0] pre;
        bit [3:0] sb;
        bit       flip;
        int       lo;
        n_edge++;
        if (n_edge >= MAXE) begin
            $display("FAIL model: edge budget exceeded");
            $fatal(1, "model overflow");
        end
        raw_at[n_edge] = r;
        for (int m = 0; m < 2; m++) begin
            pre        = ms[m];
            msettle[m] = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                lo   = n_edge - md[m] + 1;
                flip = (lo > lastf[m][ch]);
                for (int j = lo; j <= n_edge && flip; j++) begin
                    sb = sync_b(j);
                    if (sb[ch] == pre[ch]) flip = 1'b0;
                end
                if (flip) begin
                    ms[m][ch]    = ~pre[ch];
                    lastf[m][ch] = n_edge;
                end else begin
                    sb = sync_b(n_edge);
                    if (n_edge > lastf[m][ch] && sb[ch] != pre[ch]) msettle[m] = 1'b1;
                end
            end
            if (n_edge % mf[m] == 0) begin
                mchg[m]   = (pre != mout[m]);
                mout[m]   = pre;
                mvalid[m] = 1'b1;
            end else begin
                mchg[m]   = 1'b0;
                mvalid[m] = 1'b0;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic compare_all();
        check("cycle A", 32'({a_vec, a_valid, a_chg, a_settle}),
              32'({mout[0], mvalid[0], mchg[0], msettle[0]}));
        check("cycle B", 32'({b_vec, b_valid, b_chg, b_settle}),
              32'({mout[1], mvalid[1], mchg[1], msettle[1]}));
    endtask

    task automatic step(input bit [3:0] r);
        @(negedge clk);
        {raw_head, raw_left, raw_barrier, raw_under} = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input bit [3:0] r);
        rst_n = 1'b0;
        {raw_head, raw_left, raw_barrier, raw_under} = r;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset A", 32'({a_vec, a_valid, a_chg, a_settle}), 32'd0);
        check("reset B", 32'({b_vec, b_valid, b_chg, b_settle}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        bit [3:0] pat;
        int       len;
        bit [3:0] exp_seen;
        int       exp_chg;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit [3:0] seen;
        int       chg_cnt;
        int       first_edge;
        int       valid_cnt;
        bit [3:0] vec12, vec16;
        bit [3:0] rv;
        int       hold;

        // Pulse from edge 1 for len edges, then idle; exp_seen is the OR of
        // every published vector for DEBOUNCE=8, FRAME=4.
        vecs[0] = '{pat: 4'b0010, len: 7,  exp_seen: 4'b0000, exp_chg: 0};
        vecs[1] = '{pat: 4'b0010, len: 9,  exp_seen: 4'b0010, exp_chg: 2};
        vecs[2] = '{pat: 4'b1111, len: 8,  exp_seen: 4'b1111, exp_chg: 2};
        vecs[3] = '{pat: 4'b0101, len: 3,  exp_seen: 4'b0000, exp_chg: 0};
        vecs[4] = '{pat: 4'b1000, len: 20, exp_seen: 4'b1000, exp_chg: 2};
        vecs[5] = '{pat: 4'b0110, len: 1,  exp_seen: 4'b0000, exp_chg: 0};

        // Reset with all raw lines high, first publish and head rise.
        do_reset(4'b1111);
        first_edge = 0;
        vec12      = 4'b1010;
        for (int k = 1; k <= 14; k++) begin
            step(4'b1111);
            if (a_valid && first_edge == 0) begin
                first_edge = n_edge;
                vec12      = a_vec;
            end
            if (n_edge == 12) check("head rise changed", 32'({a_head, a_chg}), 32'b11);
            if (n_edge == 8)  check("head low at edge 8", 32'(a_head), 32'd0);
        end
        check("first valid edge", first_edge, 4);
        check("first vector", 32'(vec12), 32'd0);

        // Table of pulses: glitch rejection and acceptance.
        for (int v = 0; v < 6; v++) begin
            do_reset(4'b0000);
            seen    = 4'b0;
            chg_cnt = 0;
            for (int k = 1; k <= 40; k++) begin
                step((k <= vecs[v].len) ? vecs[v].pat : 4'b0000);
                if (a_valid) seen |= a_vec;
                if (a_chg) chg_cnt++;
            end
            check($sformatf("vec%0d seen", v), 32'(seen), 32'(vecs[v].exp_seen));
            check($sformatf("vec%0d changes", v), chg_cnt, vecs[v].exp_chg);
        end

        // Bounce on under: 1x5, 0x1, then steady 1; count restarts after the 0.
        do_reset(4'b0000);
        first_edge = 0;
        chg_cnt    = 0;
        for (int k = 1; k <= 30; k++) begin
            step((k == 6) ? 4'b0000 : 4'b0001);
            if (a_under && first_edge == 0) first_edge = n_edge;
            if (a_chg) chg_cnt++;
        end
        check("bounce under rise edge", first_edge, 20);
        check("bounce changes", chg_cnt, 1);

        // Coherence: left from edge 3, under from edge 5 -> flips at 12 and 14.
        do_reset(4'b0000);
        chg_cnt = 0;
        vec12   = 4'b1111;
        vec16   = 4'b0000;
        for (int k = 1; k <= 24; k++) begin
            step((k < 3) ? 4'b0000 : (k < 5) ? 4'b0100 : 4'b0101);
            if (a_chg) chg_cnt++;
            if (n_edge == 12) vec12 = a_vec;
            if (n_edge == 16) vec16 = a_vec;
        end
        check("coherence publish 12", 32'(vec12), 32'b0000);
        check("coherence publish 16", 32'(vec16), 32'b0101);
        check("coherence changes", chg_cnt, 1);

        // Asynchronous reset between edges while settling with outputs high.
        do_reset(4'b0000);
        for (int k = 1; k <= 20; k++) step(4'b1111);
        for (int k = 1; k <= 4; k++) step(4'b0000);
        check("pre-reset state", 32'({a_vec, a_settle}), 32'b11111);
        #2 rst_n = 1'b0;
        #1;
        check("async reset A", 32'({a_vec, a_valid, a_chg, a_settle}), 32'd0);
        check("async reset B", 32'({b_vec, b_valid, b_chg, b_settle}), 32'd0);

        // Minimum parameters (instance B): step appears after 4 edges.
        do_reset(4'b0000);
        first_edge = 0;
        valid_cnt  = 0;
        for (int k = 1; k <= 6; k++) begin
            step(4'b1111);
            if (b_vec == 4'b1111 && first_edge == 0) first_edge = n_edge;
            if (b_valid) valid_cnt++;
        end
        check("min params latency", first_edge, 4);
        check("min params valid every cycle", valid_cnt, 6);

        // Randomised runs checked cycle by cycle against the model.
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(4'($urandom));
            while (n_edge < 500) begin
                if ($urandom_range(0, 3) == 0) rv = 4'($urandom);
                else rv = {raw_head, raw_left, raw_barrier, raw_under} ^ (4'b0001 << $urandom_range(0, 3));
                hold = $urandom_range(1, 12);
                for (int h = 0; h < hold; h++) step(rv);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
